// File: rtl/hamming_pkg.sv
// Shared helpers for extended-Hamming SECDED code layout.
// Bit 0 is overall parity; parity bits sit at power-of-two positions.
package hamming_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_CW = 72;

  function automatic int par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int data_pos(input int i);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 3; pos < 2 * MAX_CW; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == i && res == 0) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_CW-1:0] hamming_encode(
    input logic [MAX_DW-1:0] data,
    input int                data_w
  );
    logic [MAX_CW-1:0] cw;
    int   pw;
    int   n;
    logic p;
    cw = '0;
    pw = par_w(data_w);
    n  = data_w + pw + 1;
    for (int i = 0; i < data_w; i++)
      cw[data_pos(i)] = data[i];
    for (int k = 0; k < pw; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < n; pos++)
        if (((pos >> k) & 1) == 1 && !is_pow2(pos))
          p = p ^ cw[pos];
      cw[1 << k] = p;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Stream bundle for the SECDED decoder: code words in, results out.
interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4
);
  localparam int PAR_W = par_w(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_code;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [PAR_W-1:0]  out_syndrome;

  modport slave (
    input  in_valid, in_code, correct_en, out_ready,
    output in_ready, out_valid, out_data,
    output out_sec, out_ded, out_syndrome
  );

  modport master (
    output in_valid, in_code, correct_en, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_sec, out_ded, out_syndrome
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity.
module hamming_syndrome #(
  parameter int CW_W  = 8,
  parameter int PAR_W = 3
) (
  input  logic [CW_W-1:0]  i_code,
  output logic [PAR_W-1:0] o_syn,
  output logic             o_par
);
  always_comb begin
    o_syn = '0;
    for (int i = 1; i < CW_W; i++)
      if (i_code[i]) o_syn = o_syn ^ PAR_W'(i);
  end

  assign o_par = ^i_code;
endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage streaming SECDED decoder with saturating error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int COUNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_secded_decoder_if.slave  bus,
  input  logic                     clr_counts,
  output logic [COUNT_W-1:0]       sec_count,
  output logic [COUNT_W-1:0]       ded_count
);
  localparam int PAR_W = par_w(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;
  localparam logic [PAR_W:0] CW_L = (PAR_W + 1)'(CW_W);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [PAR_W-1:0]  w_syn;
  logic              w_par;
  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_par;
  logic              r_s1_cen;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_sec;
  logic              r_ded;
  logic [PAR_W-1:0]  r_syn;
  logic [COUNT_W-1:0] r_sec_cnt;
  logic [COUNT_W-1:0] r_ded_cnt;

  logic              w_s1_rdy;
  logic              w_s2_rdy;
  logic              w_big;
  logic              w_zero;
  logic              w_sec;
  logic              w_ded;
  logic              w_hs;
  logic [CW_W-1:0]   w_fix;
  logic [DATA_W-1:0] w_data;

  hamming_syndrome #(
    .CW_W  (CW_W),
    .PAR_W (PAR_W)
  ) u_syn (
    .i_code (bus.in_code),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  assign w_s2_rdy     = !r_s2_valid || bus.out_ready;
  assign w_s1_rdy     = !r_s1_valid || w_s2_rdy;
  assign bus.in_ready = w_s1_rdy;

  // S beyond the last position can only come from a multi-bit error
  assign w_big  = {1'b0, r_s1_syn} >= CW_L;
  assign w_zero = (r_s1_syn == '0);
  assign w_sec  = r_s1_par && !w_big;
  assign w_ded  = r_s1_par ? w_big : !w_zero;

  always_comb begin
    w_fix = r_s1_code;
    if (w_sec && r_s1_cen && !w_zero)
      w_fix[r_s1_syn] = ~r_s1_code[r_s1_syn];
    w_data = '0;
    for (int i = 0; i < DATA_W; i++)
      w_data[i] = w_fix[data_pos(i)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s1_cen   <= 1'b0;
    end else if (w_s1_rdy) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_code <= bus.in_code;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
        r_s1_cen  <= bus.correct_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_sec      <= 1'b0;
      r_ded      <= 1'b0;
      r_syn      <= '0;
    end else if (w_s2_rdy) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= w_data;
        r_sec  <= w_sec;
        r_ded  <= w_ded;
        r_syn  <= r_s1_syn;
      end
    end
  end

  assign w_hs = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (clr_counts) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_hs && r_sec && r_sec_cnt != CNT_MAX)
        r_sec_cnt <= r_sec_cnt + COUNT_W'(1);
      if (w_hs && r_ded && r_ded_cnt != CNT_MAX)
        r_ded_cnt <= r_ded_cnt + COUNT_W'(1);
    end
  end

  assign bus.out_valid    = r_s2_valid;
  assign bus.out_data     = r_data;
  assign bus.out_sec      = r_sec;
  assign bus.out_ded      = r_ded;
  assign bus.out_syndrome = r_syn;
  assign sec_count        = r_sec_cnt;
  assign ded_count        = r_ded_cnt;
endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Parametrised, pipelined single-error-correct / double-error-detect (SECDED) decoder for extended Hamming code words, streaming with valid/ready handshakes on both sides. It generalises the team's 4-bit Hamming(7,4) encoder to any data width and adds overall parity, correction, error classification and saturating error statistics. It sits on the receive side of any link or memory that the matching encoder protects.

## Interface
- `DATA_W`, 4: data bits per word, minimum 1.
- `COUNT_W`, 16: width of each error counter.
- Derived, not overridable: `PAR_W` is the smallest P with 2^P ≥ DATA_W+P+1. `CW_W` = DATA_W+PAR_W+1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: code word valid.
- `in_ready` out 1: decoder can accept.
- `in_code` in CW_W: code word.
- `correct_en` in 1: when 0, the block detects errors only and never flips bits. Sampled with the word.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: decoded data.
- `out_sec` out 1: single error seen. Data corrected if correct_en was 1.
- `out_ded` out 1: uncorrectable error. Data passed raw.
- `out_syndrome` out PAR_W: syndrome of the word.
- `clr_counts` in 1: synchronous clear of both counters.
- `sec_count` out COUNT_W: saturating count of single errors.
- `ded_count` out COUNT_W: saturating count of uncorrectable errors.

## Operation
- Code layout:
  - Bit 0 is the overall even parity over all CW_W bits.
  - Bits 1..CW_W-1 are Hamming positions. Parity bits sit at positions 2^k.
  - Data bits fill the remaining positions in ascending order, with data[0] at the lowest.
  - Parity at 2^k is the XOR of all positions whose index has bit k set.
- Syndrome S is the XOR of the indices of all set bits in positions 1..CW_W-1. P is the XOR of all CW_W bits.
- Classification:
  - S=0, P=0: clean.
  - P=1, S=0: bit 0 flipped. Set sec. Data unchanged.
  - P=1, 0<S<CW_W: set sec. Flip position S if correct_en.
  - P=1, S≥CW_W: set ded. Data raw.
  - P=0, S≠0: set ded. Data raw.
- sec and ded are never both 1.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) when the word's sec or ded is 1.
  - Saturate at 2^COUNT_W−1. No wrap.
  - clr_counts wins over a simultaneous increment: the result is 0.

## Timing
- Two register stages.
  - S1 registers the code word, S, P and correct_en.
  - S2 registers out_data, out_sec, out_ded and out_syndrome.
- Latency is 2 cycles from the input handshake to out_valid while out_ready stays high. Throughput is 1 word per cycle.
- Each stage advances when it is empty or the next stage advances.
  - in_ready = !s1_valid || s1_advance.
  - The combinational ready path is allowed. No skid buffer.
- While out_valid=1 and out_ready=0, out_data, out_sec, out_ded and out_syndrome hold stable, and the input stalls once S1 is full.
- Reset (asynchronous, any time, including mid-stream):
  - out_valid=0, out_data=0, out_sec=0, out_ded=0, out_syndrome=0, sec_count=0, ded_count=0.
  - Both stage valids clear, so in-flight words are dropped.
  - in_ready=1 after reset.

## Structure
- Package `hamming_pkg` holds:
  - Function `par_w(data_w)`.
  - Function `is_pow2(pos)`.
  - Function `data_pos(i)`, giving the code position of data bit i.
  - Function `hamming_encode(data)`, shared with the future parametrised encoder and the bench's reference model.
- One sub-module, `hamming_syndrome`: combinational, in_code → {S, P}. S1 registers its outputs.
- Correction and data extraction live in the top level.

## Test plan
- DATA_W=4, clean words, out_ready=1:
  - 0x0F → data 0001, sec=0, ded=0.
  - 0xFF → data 1111, sec=0, ded=0.
  - Both arrive 2 cycles after acceptance, back-to-back with no bubbles.
- DATA_W=4, 0x2F (position 5 flipped):
  - correct_en=1 → data 0001, sec=1, syndrome 5, sec_count +1.
  - correct_en=0 → data 0011, sec=1.
- DATA_W=4, 0x0E (bit 0 flipped) → data 0001, sec=1, syndrome 0.
- DATA_W=4, 0x6F (positions 5 and 6 flipped) → data 0111, ded=1, sec=0, syndrome 3, ded_count +1.
- DATA_W=8, CW_W=13, word with S=13 and P=1 → ded=1, data raw.
- Random out_ready stalls: outputs hold stable and no words are lost or duplicated. Additionally:
  - COUNT_W=2: counter saturates at 3.
  - clr_counts asserted together with an error handshake → counter reads 0.
  - rst mid-stream → out_valid=0 and counters 0 asynchronously.
